// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
package hazard_ctrl_pkg;

   localparam int REG_IDX_W  = 5;
   localparam int HC_STATE_W = 2;

   typedef enum logic [HC_STATE_W-1:0] {
      HC_INIT      = 2'd0,
      HC_RUN       = 2'd1,
      HC_DMEM_WAIT = 2'd2
   } hc_state_e;

   typedef struct packed {
      logic rf_reset;
      logic if_stall;
      logic id_stall;
      logic id_clr;
      logic ex_clr;
      logic mem_stall;
      logic busy;
   } hc_ctrl_t;

   localparam hc_ctrl_t CTRL_HOLD = '{
      rf_reset: 1'b0, if_stall: 1'b1, id_stall: 1'b1, id_clr: 1'b1,
      ex_clr: 1'b1, mem_stall: 1'b1, busy: 1'b1};

   localparam hc_ctrl_t CTRL_RUN = '{
      rf_reset: 1'b1, if_stall: 1'b0, id_stall: 1'b0, id_clr: 1'b0,
      ex_clr: 1'b0, mem_stall: 1'b0, busy: 1'b0};

   function automatic logic load_use(
      input logic                 ld,
      input logic                 dst_en,
      input logic [REG_IDX_W-1:0] dst,
      input logic                 rs1_en,
      input logic [REG_IDX_W-1:0] rs1,
      input logic                 rs2_en,
      input logic [REG_IDX_W-1:0] rs2
   );
      return ld & dst_en & (dst != '0) &
             ((rs1_en & (rs1 == dst)) | (rs2_en & (rs2 == dst)));
   endfunction

endpackage

// File: rtl/hc_sat_counter.sv
// Performance counter that sticks at all-ones instead of wrapping.
module hc_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (clr)
         r_count <= '0;
      else if (inc && (r_count != '1))
         r_count <= r_count + CNT_W'(1);
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: init hold, load-use stall, branch flush,
// memory-wait freeze, plus stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int RST_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [REG_IDX_W-1:0] id_rs1,
   input  logic                 id_rs1_en,
   input  logic [REG_IDX_W-1:0] id_rs2,
   input  logic                 id_rs2_en,
   input  logic [REG_IDX_W-1:0] ex_dest_reg,
   input  logic                 ex_dest_en,
   input  logic                 ex_is_load,
   input  logic                 ex_branch_taken,
   input  logic                 imem_busy,
   input  logic                 dmem_busy,
   output logic                 rf_reset,
   output logic                 if_stall,
   output logic                 id_stall,
   output logic                 id_clr,
   output logic                 ex_clr,
   output logic                 mem_stall,
   output logic                 busy,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam int CW = $clog2(RST_CYCLES + 1);

   hc_state_e r_state;
   hc_state_e w_next;
   logic [CW-1:0] r_cnt;
   hc_ctrl_t w_ctrl;
   logic w_stall_inc;
   logic w_flush_inc;
   logic w_hazard;

   assign w_hazard = load_use(ex_is_load, ex_dest_en, ex_dest_reg,
                              id_rs1_en, id_rs1, id_rs2_en, id_rs2);

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= HC_INIT;
         r_cnt   <= CW'(RST_CYCLES);
      end else begin
         r_state <= w_next;
         if (r_state == HC_INIT)
            r_cnt <= r_cnt - CW'(1);
      end
   end

   always_comb begin
      w_ctrl      = CTRL_RUN;
      w_next      = r_state;
      w_stall_inc = 1'b0;
      w_flush_inc = 1'b0;
      if (clr) begin
         w_ctrl = CTRL_HOLD;
         w_next = HC_INIT;
      end else if (r_state == HC_INIT) begin
         w_ctrl = CTRL_HOLD;
         if (r_cnt == CW'(1))
            w_next = HC_RUN;
      end else begin
         // A finished memory wait falls straight into run rules.
         w_next = HC_RUN;
         if (dmem_busy) begin
            w_ctrl.mem_stall = 1'b1;
            w_ctrl.if_stall  = 1'b1;
            w_ctrl.id_stall  = 1'b1;
            w_next           = HC_DMEM_WAIT;
            w_stall_inc      = 1'b1;
         end else if (ex_branch_taken) begin
            w_ctrl.id_clr = 1'b1;
            w_ctrl.ex_clr = 1'b1;
            w_flush_inc   = 1'b1;
         end else if (w_hazard) begin
            w_ctrl.if_stall = 1'b1;
            w_ctrl.id_stall = 1'b1;
            w_ctrl.ex_clr   = 1'b1;
            w_stall_inc     = 1'b1;
         end else if (imem_busy) begin
            w_ctrl.if_stall = 1'b1;
            w_ctrl.id_clr   = 1'b1;
         end
      end
   end

   assign rf_reset  = w_ctrl.rf_reset;
   assign if_stall  = w_ctrl.if_stall;
   assign id_stall  = w_ctrl.id_stall;
   assign id_clr    = w_ctrl.id_clr;
   assign ex_clr    = w_ctrl.ex_clr;
   assign mem_stall = w_ctrl.mem_stall;
   assign busy      = w_ctrl.busy;

   hc_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (clr),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

   hc_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (clr),
      .inc   (w_flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-level reference model.
module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   localparam int RST = 4;
   localparam int CW  = 4;
   localparam int MAXC = (1 << CW) - 1;

   bit clk = 1'b0;
   logic clr;
   logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_dest_reg;
   logic id_rs1_en, id_rs2_en, ex_dest_en, ex_is_load;
   logic ex_branch_taken, imem_busy, dmem_busy;
   logic rf_reset, if_stall, id_stall, id_clr, ex_clr, mem_stall, busy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_vec = 0;
   int n_err = 0;

   int m_init = 0;
   int m_stall = 0;
   int m_flush = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.RST_CYCLES(RST), .CNT_W(CW)) dut (
      .clk(clk), .clr(clr),
      .id_rs1(id_rs1), .id_rs1_en(id_rs1_en),
      .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
      .ex_dest_reg(ex_dest_reg), .ex_dest_en(ex_dest_en),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .imem_busy(imem_busy), .dmem_busy(dmem_busy),
      .rf_reset(rf_reset), .if_stall(if_stall), .id_stall(id_stall),
      .id_clr(id_clr), .ex_clr(ex_clr), .mem_stall(mem_stall),
      .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
      end
   endtask

   function automatic bit hz();
      if (!(ex_is_load && ex_dest_en && ex_dest_reg != 0)) return 0;
      return (id_rs1_en && id_rs1 == ex_dest_reg) ||
             (id_rs2_en && id_rs2 == ex_dest_reg);
   endfunction

   // Reference model: outputs as a function of the spec rules.
   always @(negedge clk) begin
      bit e_rf, e_if, e_id, e_idc, e_exc, e_mem, e_busy;
      e_rf = 1; e_if = 0; e_id = 0; e_idc = 0;
      e_exc = 0; e_mem = 0; e_busy = 0;
      if (clr === 1'b1 || m_init > 0) begin
         e_rf = 0; e_if = 1; e_id = 1; e_idc = 1;
         e_exc = 1; e_mem = 1; e_busy = 1;
      end else if (dmem_busy) begin
         e_mem = 1; e_if = 1; e_id = 1;
      end else if (ex_branch_taken) begin
         e_idc = 1; e_exc = 1;
      end else if (hz()) begin
         e_if = 1; e_id = 1; e_exc = 1;
      end else if (imem_busy) begin
         e_if = 1; e_idc = 1;
      end
      chk("rf_reset", int'(rf_reset), int'(e_rf));
      chk("if_stall", int'(if_stall), int'(e_if));
      chk("id_stall", int'(id_stall), int'(e_id));
      chk("id_clr", int'(id_clr), int'(e_idc));
      chk("ex_clr", int'(ex_clr), int'(e_exc));
      chk("mem_stall", int'(mem_stall), int'(e_mem));
      chk("busy", int'(busy), int'(e_busy));
      chk("stall_cnt", int'(stall_cnt), m_stall);
      chk("flush_cnt", int'(flush_cnt), m_flush);
   end

   always @(posedge clk) begin
      if (clr) begin
         m_init  <= RST;
         m_stall <= 0;
         m_flush <= 0;
      end else if (m_init > 0) begin
         m_init <= m_init - 1;
      end else if (dmem_busy || (!ex_branch_taken && hz())) begin
         if (m_stall < MAXC) m_stall <= m_stall + 1;
      end else if (ex_branch_taken) begin
         if (m_flush < MAXC) m_flush <= m_flush + 1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = 0; id_rs1_en = 0; id_rs2 = 0; id_rs2_en = 0;
      ex_dest_reg = 0; ex_dest_en = 0; ex_is_load = 0;
      ex_branch_taken = 0; imem_busy = 0; dmem_busy = 0;
   endtask

   task automatic load5(input int rs, input bit use_rs1);
      ex_is_load = 1; ex_dest_en = 1; ex_dest_reg = REG_IDX_W'(rs);
      if (use_rs1) begin
         id_rs1_en = 1; id_rs1 = REG_IDX_W'(rs);
      end else begin
         id_rs2_en = 1; id_rs2 = REG_IDX_W'(rs);
      end
   endtask

   task automatic do_reset(input int n);
      clr = 1;
      repeat (n) nxt();
      clr = 0;
      for (int k = 0; k < RST; k++) begin
         at_neg();
         chk("init_rf_low", int'(rf_reset), 0);
         chk("init_busy", int'(busy), 1);
         nxt();
      end
      at_neg();
      chk("post_rf", int'(rf_reset), 1);
      chk("post_busy", int'(busy), 0);
      chk("post_stall", int'(if_stall | id_stall | mem_stall), 0);
      chk("post_scnt", int'(stall_cnt), 0);
      chk("post_fcnt", int'(flush_cnt), 0);
   endtask

   initial begin
      idle();
      do_reset(3);
      nxt();

      load5(5, 0);
      at_neg();
      chk("lu_stall", int'(if_stall & id_stall & ex_clr), 1);
      nxt(); idle();
      at_neg();
      chk("lu_cnt", int'(stall_cnt), 1);
      nxt();

      load5(0, 0);
      at_neg();
      chk("x0_nostall", int'(if_stall), 0);
      nxt(); idle();

      load5(5, 0);
      ex_branch_taken = 1;
      at_neg();
      chk("br_ifs", int'(if_stall), 0);
      chk("br_clr", int'(id_clr & ex_clr), 1);
      nxt(); idle();
      at_neg();
      chk("br_fcnt", int'(flush_cnt), 1);
      chk("br_scnt", int'(stall_cnt), 1);
      nxt();

      for (int k = 0; k < 3; k++) begin
         dmem_busy = 1;
         ex_branch_taken = (k == 1);
         at_neg();
         chk("dm_stall", int'(mem_stall & if_stall & id_stall), 1);
         chk("dm_noflush", int'(id_clr), 0);
         nxt();
      end
      idle();
      at_neg();
      chk("dm_scnt", int'(stall_cnt), 4);
      chk("dm_fcnt", int'(flush_cnt), 1);
      chk("dm_after", int'(mem_stall | if_stall | id_stall), 0);
      nxt();

      for (int k = 0; k < 2; k++) begin
         imem_busy = 1;
         at_neg();
         chk("im_ctl", int'(if_stall & id_clr), 1);
         nxt();
      end
      idle();
      at_neg();
      chk("im_scnt", int'(stall_cnt), 4);
      nxt();

      load5(7, 1);
      at_neg();
      chk("rs1_stall", int'(id_stall), 1);
      nxt(); idle();
      load5(7, 1);
      id_rs1_en = 0;
      at_neg();
      chk("rs1_dis", int'(id_stall), 0);
      nxt(); idle();

      dmem_busy = 1;
      nxt(); nxt();
      clr = 1;
      nxt();
      dmem_busy = 0;
      clr = 0;
      at_neg();
      chk("abort_cnt", int'(stall_cnt), 0);
      chk("abort_busy", int'(busy), 1);
      for (int k = 1; k < RST; k++) nxt();
      nxt();
      at_neg();
      chk("abort_run", int'(busy), 0);
      nxt();

      dmem_busy = 1;
      repeat (MAXC + 3) nxt();
      idle();
      at_neg();
      chk("sat_cnt", int'(stall_cnt), MAXC);
      nxt();
      nxt();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
